// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control FSM:
// opcode/funct codes, ALUC OpA codes, state encoding and the decode helper.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    localparam logic [2:0] OPA_DECODE = 3'b010;
    localparam logic [2:0] OPA_IDLE   = 3'b000;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_MD  = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_WB_LW    = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_ILLEGAL  = 4'd11
    } state_e;

    // State that follows DECODE for a given instruction.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
        state_e nxt;
        unique case (op)
            OP_R:                              nxt = (funct == FN_MULT || funct == FN_DIV)
                                                     ? ST_EXEC_MD : ST_EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:                      nxt = ST_MEM_ADDR;
            default:                           nxt = ST_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath: instruction
// sequencing, memory wait handling, fixed MULT/DIV window and retire counter.
//
// state    | meaning
// FETCH    | read instruction; IR/PC update when memory ready
// DECODE   | pick execute path from op/funct
// EXEC_R   | R-type ALU operation
// EXEC_MD  | MULT/DIV, held for MD_CYCLES cycles
// WB_R     | write rd from ALU
// EXEC_I   | immediate ALU operation
// WB_I     | write rt from ALU
// MEM_ADDR | compute LW/SW address
// MEM_RD   | load data read, wait for memory
// WB_LW    | write rt from MDR
// MEM_WR   | store data write, wait for memory
// ILLEGAL  | flag unsupported opcode for one cycle
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       instr_op,
    input  logic [5:0]       instr_funct,
    input  logic             mem_ready,
    output logic [2:0]       OpA,
    output logic             itr_sel,
    output logic             alu_src_b,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_wr,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned MD_W = $clog2(MD_CYCLES + 1);

    state_e            state_q, state_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            md_cnt_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        retire     = 1'b0;
        OpA        = OPA_IDLE;
        itr_sel    = 1'b0;
        alu_src_b  = 1'b0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = decode_next(instr_op, instr_funct);
                // Down-counter starts at MD_CYCLES-1 so EXEC_MD lasts exactly MD_CYCLES.
                if (state_d == ST_EXEC_MD) md_cnt_d = MD_W'(MD_CYCLES - 1);
            end
            ST_EXEC_R: begin
                OpA     = OPA_DECODE;
                state_d = ST_WB_R;
            end
            ST_EXEC_MD: begin
                OpA = OPA_DECODE;
                if (md_cnt_q == '0) state_d = ST_WB_R;
                else                md_cnt_d = md_cnt_q - 1'b1;
            end
            ST_WB_R: begin
                OpA     = OPA_DECODE;
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                OpA       = OPA_DECODE;
                itr_sel   = 1'b1;
                alu_src_b = 1'b1;
                if (state_q == ST_EXEC_I) state_d = ST_WB_I;
                else                      state_d = (instr_op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_WB_I: begin
                OpA       = OPA_DECODE;
                itr_sel   = 1'b1;
                alu_src_b = 1'b1;
                reg_wr    = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM_RD: begin
                OpA       = OPA_DECODE;
                itr_sel   = 1'b1;
                alu_src_b = 1'b1;
                mem_rd    = 1'b1;
                if (mem_ready) state_d = ST_WB_LW;
            end
            ST_WB_LW: begin
                mem_to_reg = 1'b1;
                reg_wr     = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                OpA       = OPA_DECODE;
                itr_sel   = 1'b1;
                alu_src_b = 1'b1;
                mem_wr    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_ILLEGAL: begin
                illegal = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
        instret   = instret_q;

        // Reset silences the datapath immediately, including an in-flight memory access.
        if (rst) begin
            OpA        = OPA_IDLE;
            itr_sel    = 1'b0;
            alu_src_b  = 1'b0;
            pc_wr      = 1'b0;
            ir_wr      = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_wr     = 1'b0;
            illegal    = 1'b0;
            instret    = '0;
        end
    end

endmodule
